// File: rtl/fir_frame_collector.sv
// fir_frame_collector
//   Sink end of the FIR output stream. Packs FRAME_LEN consecutive valid
//   samples into one frame and hands complete frames to the downstream FFT
//   stage over a valid/ready handshake. Two storage banks are used ping-pong
//   style so one frame can fill while the other waits to be read.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset (discards all stored data)
//   fir_valid    in   fir_d holds a valid sample this cycle
//   fir_d        in   FIR output sample (signed, passed through unmodified)
//   frame_clr    in   discard the partially filled frame
//   frame_ready  in   downstream accepts the presented frame this cycle
//   frame_valid  out  a complete frame is presented
//   frame_data   out  frame; sample k at [k*DATA_W +: DATA_W], k=0 is oldest
//   frame_idx    out  sequence number of the presented frame (wraps 255->0)
//   drop_pulse   out  one-cycle pulse: a sample was discarded (both banks full)
module fir_frame_collector #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fir_valid,
  input  logic [DATA_W-1:0]           fir_d,
  input  logic                        frame_clr,
  input  logic                        frame_ready,
  output logic                        frame_valid,
  output logic [DATA_W*FRAME_LEN-1:0] frame_data,
  output logic [7:0]                  frame_idx,
  output logic                        drop_pulse
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  bank_state_t       bank_state [2];
  logic [DATA_W-1:0] bank_mem   [2][FRAME_LEN];
  logic              wr_bank;
  logic              rd_bank;
  logic [IDX_W-1:0]  wr_idx;
  logic              handshake;

  // The read side is a pure decode of the registered bank state, so the frame
  // appears the cycle after its last sample is written and stays stable.
  assign frame_valid = (bank_state[rd_bank] == FULL);
  assign handshake   = frame_valid & frame_ready;

  always_comb begin
    frame_data = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      frame_data[k*DATA_W +: DATA_W] = bank_mem[rd_bank][k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_idx        <= '0;
      frame_idx     <= 8'd0;
      drop_pulse    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < FRAME_LEN; k++) begin
          bank_mem[b][k] <= '0;
        end
      end
    end else begin
      drop_pulse <= 1'b0;

      // A handshaken bank is only visible as EMPTY to the write side from the
      // next cycle, because the write side below tests the current state.
      // The read bank is FULL and the write bank never is when writing, so
      // the two updates never target the same bank entry.
      if (handshake) begin
        bank_state[rd_bank] <= EMPTY;
        rd_bank             <= ~rd_bank;
        frame_idx           <= frame_idx + 8'd1;
      end

      if (frame_clr) begin
        // Only a partial frame is discarded; completed frames are kept.
        wr_idx <= '0;
        if (bank_state[wr_bank] == FILLING) begin
          bank_state[wr_bank] <= EMPTY;
        end
      end else if (fir_valid) begin
        if (bank_state[wr_bank] == FULL) begin
          drop_pulse <= 1'b1;
        end else begin
          bank_mem[wr_bank][wr_idx] <= fir_d;
          if (wr_idx == LAST_IDX) begin
            bank_state[wr_bank] <= FULL;
            wr_idx              <= '0;
            wr_bank             <= ~wr_bank;
          end else begin
            bank_state[wr_bank] <= FILLING;
            wr_idx              <= wr_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule
